// File: rtl/xrv_tag_pkg.sv
// Shared types and defaults for the xrv tag allocator.
package xrv_tag_pkg;

  localparam int XRV_NUM_TAGS = 8;
  localparam int XRV_TAG_W    = $clog2(XRV_NUM_TAGS);

  typedef logic [XRV_TAG_W-1:0] tag_t;
  typedef logic [XRV_TAG_W:0]   cnt_t;

endpackage

// File: rtl/xrv_ff_one.sv
// Find-first-one: index of the lowest set bit of in_i, plus an all-zero flag.
module xrv_ff_one #(
  parameter  int DATA_WIDTH_P = 8,
  localparam int IDX_W        = (DATA_WIDTH_P > 1) ? $clog2(DATA_WIDTH_P) : 1
) (
  input  logic [DATA_WIDTH_P-1:0] in_i,
  output logic [IDX_W-1:0]        first_one_o,
  output logic                    no_ones_o
);

  logic [DATA_WIDTH_P:0]   lower_any;
  logic [DATA_WIDTH_P-1:0] onehot;

  assign lower_any[0] = 1'b0;

  // Prefix-OR chain isolates the lowest set bit as a one-hot vector.
  for (genvar gi = 0; gi < DATA_WIDTH_P; gi++) begin : g_chain
    assign lower_any[gi+1] = lower_any[gi] | in_i[gi];
    assign onehot[gi]      = in_i[gi] & ~lower_any[gi];
  end

  always_comb begin
    first_one_o = '0;
    for (int i = 0; i < DATA_WIDTH_P; i++) begin
      if (onehot[i]) first_one_o = first_one_o | IDX_W'(i);
    end
  end

  assign no_ones_o = ~lower_any[DATA_WIDTH_P];

endmodule

// File: rtl/xrv_tag_alloc.sv
// Tag allocator: offers the lowest free tag through a registered valid/ready port.
// Define XRV_TAG_ALLOC_FREE_CHK_EN to enable the sticky illegal-free flag on error_o.
module xrv_tag_alloc
  import xrv_tag_pkg::*;
#(
  parameter  int NUM_TAGS_P = XRV_NUM_TAGS,
  localparam int TAG_W      = $clog2(NUM_TAGS_P),
  localparam int CNT_W      = $clog2(NUM_TAGS_P) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  output logic             alloc_valid_o,
  output logic [TAG_W-1:0] alloc_tag_o,
  input  logic             alloc_ready_i,
  input  logic             free_valid_i,
  input  logic [TAG_W-1:0] free_tag_i,
  output logic [CNT_W-1:0] in_use_o,
  output logic             error_o
);

  logic [NUM_TAGS_P-1:0] free_q, free_d;
  logic                  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [TAG_W-1:0]      ff_idx;
  logic                  ff_none;
  logic                  fire, load;
  logic                  in_range, tag_is_free, tag_is_held, free_legal;

  xrv_ff_one #(
    .DATA_WIDTH_P(NUM_TAGS_P)
  ) u_ff_one (
    .in_i        (free_q),
    .first_one_o (ff_idx),
    .no_ones_o   (ff_none)
  );

  assign fire = valid_q & alloc_ready_i;
  assign load = ~valid_q | fire;

  // Zero-extend before comparing so non-power-of-two pools reject stray indices.
  assign in_range    = {1'b0, free_tag_i} < CNT_W'(NUM_TAGS_P);
  assign tag_is_free = in_range && free_q[free_tag_i];
  assign tag_is_held = valid_q && (free_tag_i == tag_q);
  assign free_legal  = free_valid_i && in_range && !tag_is_free && !tag_is_held;

  always_comb begin
    free_d  = free_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;

    if (free_legal) free_d[free_tag_i] = 1'b1;

    // Selection uses the pre-edge bitmap, so a freed tag is offered one cycle later.
    if (load) begin
      valid_d = ~ff_none;
      if (!ff_none) begin
        tag_d          = ff_idx;
        free_d[ff_idx] = 1'b0;
      end
    end

    case ({fire, free_legal})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (flush_i) begin
      free_d  = '1;
      valid_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_q  <= '1;
      valid_q <= 1'b0;
      tag_q   <= '0;
      cnt_q   <= '0;
    end else begin
      free_q  <= free_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alloc_valid_o = valid_q;
  assign alloc_tag_o   = tag_q;
  assign in_use_o      = cnt_q;

`ifdef XRV_TAG_ALLOC_FREE_CHK_EN
  logic err_q;
  logic free_bad;

  assign free_bad = free_valid_i && !free_legal;

  // Sticky until reset; flush deliberately leaves it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i)         err_q <= 1'b0;
    else if (free_bad) err_q <= 1'b1;
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

endmodule
